// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Holds the operation/state encodings and the conditional-negate helper.
package muldiv_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } muldiv_state_t;

   // Wide enough for a 2*WIDTH product with WIDTH up to 64.
   localparam int MD_VW = 128;
   typedef logic [MD_VW-1:0] md_vec_t;

   // Two's-complement negate when neg is set; low bits are width-agnostic.
   function automatic md_vec_t f_cneg(input md_vec_t x, input logic neg);
      return neg ? (~x + md_vec_t'(1)) : x;
   endfunction

   function automatic logic f_is_signed(input muldiv_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic f_is_div(input muldiv_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle.
module mult_div_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   muldiv_state_t      r_state;
   muldiv_op_t         r_op;
   logic               r_sa;
   logic               r_sb;
   logic               r_bzero;
   logic [WIDTH-1:0]   r_a_raw;
   logic [WIDTH-1:0]   r_mag_a;
   logic [WIDTH-1:0]   r_mag_b;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH:0]     r_rem;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic               r_dbz;

   muldiv_op_t         w_in_op;
   logic               w_in_sa;
   logic               w_in_sb;
   md_vec_t            w_va;
   md_vec_t            w_vb;
   logic [WIDTH-1:0]   w_in_mag_a;
   logic [WIDTH-1:0]   w_in_mag_b;
   logic               w_is_div;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic               w_ge;
   md_vec_t            w_vp;
   md_vec_t            w_vq;
   md_vec_t            w_vr;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rmd;
   logic               w_unused_bits;

   // Operand decode at accept: sign flags and magnitudes.
   always_comb begin
      w_in_op    = muldiv_op_t'(op);
      w_in_sa    = f_is_signed(w_in_op) & op_a[WIDTH-1];
      w_in_sb    = f_is_signed(w_in_op) & op_b[WIDTH-1];
      w_va       = f_cneg(md_vec_t'(op_a), w_in_sa);
      w_vb       = f_cneg(md_vec_t'(op_b), w_in_sb);
      w_in_mag_a = w_va[WIDTH-1:0];
      w_in_mag_b = w_vb[WIDTH-1:0];
   end

   // One iteration step for each datapath, plus final sign correction.
   always_comb begin
      w_is_div = f_is_div(r_op);
      w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + (r_acc[0] ? {1'b0, r_mag_a} : '0);
      w_shift  = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
      w_ge     = (w_shift >= {1'b0, r_mag_b});
      w_diff   = w_shift - {1'b0, r_mag_b};
      w_vp     = f_cneg(md_vec_t'(r_acc), r_sa ^ r_sb);
      w_vq     = f_cneg(md_vec_t'(r_acc[WIDTH-1:0]), r_sa ^ r_sb);
      w_vr     = f_cneg(md_vec_t'(r_rem[WIDTH-1:0]), r_sa);
      w_prod   = w_vp[2*WIDTH-1:0];
      w_quo    = w_vq[WIDTH-1:0];
      w_rmd    = w_vr[WIDTH-1:0];
   end

   // Upper helper bits are zero-extension artefacts.
   assign w_unused_bits = ^{w_va[MD_VW-1:WIDTH], w_vb[MD_VW-1:WIDTH],
                            w_vp[MD_VW-1:2*WIDTH], w_vq[MD_VW-1:WIDTH],
                            w_vr[MD_VW-1:WIDTH], r_rem[WIDTH]};

   // Control FSM with iteration datapath and HI/LO ownership.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= MD_MULT;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_bzero <= 1'b0;
         r_a_raw <= '0;
         r_mag_a <= '0;
         r_mag_b <= '0;
         r_acc   <= '0;
         r_rem   <= '0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (hi_we) r_hi <= wr_data;
               if (lo_we) r_lo <= wr_data;
               if (start) begin
                  r_op    <= w_in_op;
                  r_sa    <= w_in_sa;
                  r_sb    <= w_in_sb;
                  r_bzero <= (op_b == '0);
                  r_a_raw <= op_a;
                  r_mag_a <= w_in_mag_a;
                  r_mag_b <= w_in_mag_b;
                  r_acc   <= f_is_div(w_in_op)
                           ? {{WIDTH{1'b0}}, w_in_mag_a}
                           : {{WIDTH{1'b0}}, w_in_mag_b};
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_dbz   <= 1'b0;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               if (w_is_div) begin
                  r_rem <= w_ge ? w_diff : w_shift;
                  r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_ge};
               end else begin
                  r_acc <= {w_sum, r_acc[WIDTH-1:1]};
               end
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) r_state <= S_FIX;
            end
            S_FIX: begin
               if (w_is_div) begin
                  if (r_bzero) begin
                     r_hi  <= r_a_raw;
                     r_lo  <= '1;
                     r_dbz <= 1'b1;
                  end else begin
                     r_hi <= w_rmd;
                     r_lo <= w_quo;
                  end
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign hi          = r_hi;
   assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, corner
// sequences and random operations against an arithmetic model.
module tb_mult_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         hi_we;
   logic         lo_we;
   logic [W-1:0] wr_data;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_vec = 0;
   int n_err = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we),
      .wr_data(wr_data), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] ehi;
      logic [W-1:0] elo;
      logic         edbz;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on 64-bit values.
   task automatic ref_model(input logic [1:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, output logic [W-1:0] rh,
                            output logic [W-1:0] rl, output logic rz);
      longint sa, sb, ua, ub;
      logic [63:0] p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      rz = 1'b0;
      p = '0; q = '0; r = '0;
      case (o)
         2'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
         2'd1: begin p = ua * ub; rh = p[63:32]; rl = p[31:0]; end
         default: begin
            if (b == '0) begin
               rh = a; rl = '1; rz = 1'b1;
            end else begin
               if (o == 2'd2) begin q = sa / sb; r = sa % sb; end
               else begin q = ua / ub; r = ua % ub; end
               rh = r[31:0]; rl = q[31:0];
            end
         end
      endcase
   endtask

   // Issue one operation; optional disturbance (start+MTHI+MTLO) at
   // cycle dis after accept. lat = edges from accept to done.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int dis,
                         output int lat, output int bcnt,
                         output logic [W-1:0] hi_acc);
      start = 1'b1; op = o; op_a = a; op_b = b;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'($urandom); op_a = $urandom; op_b = $urandom;
      hi_acc = hi;
      chk("busy_at_accept", busy, 1);
      chk("dbz_clear_on_accept", div_by_zero, 0);
      lat = -1;
      bcnt = 0;
      for (int n = 1; n <= 60; n++) begin
         if (n == dis) begin
            start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
            wr_data = 32'hDEAD_BEEF; op_b = 32'd1;
         end
         @(posedge clk); #1;
         if (n == dis) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
         if (done) begin lat = n; break; end
         if (busy) bcnt++;
      end
      if (lat < 0) begin
         n_vec++; n_err++;
         $display("FAIL done_timeout: got no done expected done");
      end
   endtask

   logic [W-1:0] eh, el, hacc, sv_lo;
   logic         ez;
   int           lat, bcnt;

   initial begin
      tbl[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      tbl[1] = '{2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
      tbl[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      tbl[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      tbl[4] = '{2'd3, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 1'b0};
      tbl[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      tbl[6] = '{2'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
      tbl[7] = '{2'd1, 32'd2,         32'd3,         32'h0000_0000, 32'h0000_0006, 1'b0};
      tbl[8] = '{2'd2, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0};
      tbl[9] = '{2'd2, 32'hFFFF_EDCC, 32'd0,         32'hFFFF_EDCC, 32'hFFFF_FFFF, 1'b1};

      rst = 1'b1; start = 1'b0; op = '0; op_a = '0; op_b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table, latency and busy window on every entry.
      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, -1, lat, bcnt, hacc);
         chk($sformatf("tbl%0d_hi", i), hi, tbl[i].ehi);
         chk($sformatf("tbl%0d_lo", i), lo, tbl[i].elo);
         chk($sformatf("tbl%0d_dbz", i), div_by_zero, tbl[i].edbz);
         chk($sformatf("tbl%0d_latency", i), 64'(lat), 33);
         chk($sformatf("tbl%0d_busy_cycles", i), 64'(bcnt), 32);
         chk($sformatf("tbl%0d_busy_at_done", i), busy, 0);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_done_pulse", i), done, 0);
         chk($sformatf("tbl%0d_dbz_hold", i), div_by_zero, tbl[i].edbz);
      end

      // Disturbance at cycle 10 is ignored.
      run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 10, lat, bcnt, hacc);
      chk("dist_hi", hi, 32'hFFFF_FFFF);
      chk("dist_lo", lo, 32'hFFFF_FFF1);
      chk("dist_latency", 64'(lat), 33);
      repeat (3) @(posedge clk);
      #1;
      chk("dist_no_second_op", busy, 0);
      chk("dist_no_second_done", done, 0);

      // MTHI in IDLE, then both strobes together.
      sv_lo = lo;
      hi_we = 1'b1; wr_data = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      hi_we = 1'b0;
      chk("mthi_hi", hi, 32'hA5A5_A5A5);
      chk("mthi_lo_kept", lo, sv_lo);
      hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h0F0F_1234;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      chk("mtboth_hi", hi, 32'h0F0F_1234);
      chk("mtboth_lo", lo, 32'h0F0F_1234);

      // MTHI together with start: lands, then overwritten.
      hi_we = 1'b1; wr_data = 32'h1111_1111;
      run_op(2'd1, 32'd2, 32'd3, -1, lat, bcnt, hacc);
      chk("mthi_start_lands", hacc, 32'h1111_1111);
      chk("mthi_start_hi", hi, 32'd0);
      chk("mthi_start_lo", lo, 32'd6);

      // Reset at cycle 5 of a DIV.
      start = 1'b1; op = 2'd2; op_a = 32'd1000; op_b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      run_op(2'd1, 32'd12345, 32'd678, -1, lat, bcnt, hacc);
      chk("postrst_hi", hi, 32'd0);
      chk("postrst_lo", lo, 32'd8369910);
      chk("postrst_latency", 64'(lat), 33);

      // Random operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         logic [1:0]   ro;
         logic [W-1:0] ra, rb;
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 15));
            2: ra = 32'h8000_0000;
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         ref_model(ro, ra, rb, eh, el, ez);
         run_op(ro, ra, rb, -1, lat, bcnt, hacc);
         chk($sformatf("rnd%0d_op%0d_%h_%h_hi", i, ro, ra, rb), hi, eh);
         chk($sformatf("rnd%0d_op%0d_%h_%h_lo", i, ro, ra, rb), lo, el);
         chk($sformatf("rnd%0d_dbz", i), div_by_zero, ez);
         chk($sformatf("rnd%0d_latency", i), 64'(lat), 33);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
